// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg
// Shared definitions for the register-file arbiter slice: FSM state
// encoding, default data/address widths and requester IDs.
// No ports (package).
package rf_arb_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_ACCESS = S_ACCESS,
        ST_RESP   = S_RESP
    } state_t;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

endpackage

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if
// Bundles the two client request/ack ports and the register file port.
//   client side : req0/1, we0/1, addr0/1, wdata0/1 -> arbiter
//                 ack0/1, rdata0/1, busy          <- arbiter
//   rf side     : rf_raddr, rf_waddr, rf_ren, rf_wen, rf_wdata <- arbiter
//                 rf_rdata -> arbiter
// Modports: slave = arbiter, master = clients plus register file.
interface regfile_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          busy;
    logic [AW-1:0] rf_raddr;
    logic [AW-1:0] rf_waddr;
    logic          rf_ren;
    logic          rf_wen;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_rdata,
        output ack0, ack1, rdata0, rdata1, busy,
               rf_raddr, rf_waddr, rf_ren, rf_wen, rf_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_rdata,
        input  ack0, ack1, rdata0, rdata1, busy,
               rf_raddr, rf_waddr, rf_ren, rf_wen, rf_wdata
    );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin chooser.
//   req0, req1 : requests
//   last       : ID of the most recently served requester
//   valid      : at least one request present
//   id         : chosen requester
module rr_pick2
    import rf_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic id
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        valid = req0 | req1;
        id    = ID0;
        if (req0 && req1) begin
            id = ~last;
        end else if (req1) begin
            id = ID1;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// Serialises register-file accesses from two clients with round-robin
// fairness. Each transaction is IDLE -> ACCESS -> RESP (3 cycles).
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : regfile_arbiter_if.slave (client ports + register file port)
module regfile_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic                Clk,
    input  logic                Rst,
    regfile_arbiter_if.slave    bus
);

    state_t        state;
    state_t        next_state;
    logic          last;
    logic          cur_we;
    logic          cur_id;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          rf_ren_q;
    logic          rf_wen_q;
    logic          ack0_q;
    logic          ack1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          pick_valid;
    logic          pick_id;
    logic          grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          ren_next;
    logic          wen_next;
    logic          ack0_next;
    logic          ack1_next;

    rr_pick2 u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Next state plus the next values of the registered outputs. The rf
    // enables are set one cycle ahead so they are high exactly in ACCESS,
    // and acks are set during ACCESS so they are high exactly in RESP.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        sel_we     = bus.we0;
        sel_addr   = bus.addr0;
        sel_wdata  = bus.wdata0;
        ren_next   = 1'b0;
        wen_next   = 1'b0;
        ack0_next  = 1'b0;
        ack1_next  = 1'b0;

        if (pick_id == ID1) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant      = 1'b1;
                    ren_next   = ~sel_we;
                    wen_next   = sel_we;
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ack0_next  = (cur_id == ID0);
                ack1_next  = (cur_id == ID1);
                next_state = ST_RESP;
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Commands are latched only on a grant, so client changes during
    // ACCESS/RESP never reach the register file. Read data is captured at
    // the end of ACCESS while rf_ren is still asserted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            last      <= ID1;
            cur_we    <= 1'b0;
            cur_id    <= ID0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            rf_ren_q  <= 1'b0;
            rf_wen_q  <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state    <= next_state;
            rf_ren_q <= ren_next;
            rf_wen_q <= wen_next;
            ack0_q   <= ack0_next;
            ack1_q   <= ack1_next;
            if (grant) begin
                cur_we    <= sel_we;
                cur_id    <= pick_id;
                cur_addr  <= sel_addr;
                cur_wdata <= sel_wdata;
            end
            if (state == ST_ACCESS) begin
                last <= cur_id;
                if (!cur_we) begin
                    if (cur_id == ID0) begin
                        rdata0_q <= bus.rf_rdata;
                    end else begin
                        rdata1_q <= bus.rf_rdata;
                    end
                end
            end
        end
    end

    assign bus.rf_raddr = cur_addr;
    assign bus.rf_waddr = cur_addr;
    assign bus.rf_wdata = cur_wdata;
    assign bus.rf_ren   = rf_ren_q;
    assign bus.rf_wen   = rf_wen_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter
// Self-checking bench for regfile_arbiter with a behavioural 16x8
// register file. Clients push the expected rdata of every transaction into
// per-port queues; a monitor pops and compares on each ack.
module tb_regfile_arbiter;
    import rf_arb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    regfile_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regfile_arbiter #(.DW(DW), .AW(AW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Register file: synchronous write, combinational read when enabled.
    logic [DW-1:0] rfMem [16] = '{default: 8'h00};

    always @(posedge Clk) begin
        if (bus.rf_wen) rfMem[bus.rf_waddr] <= bus.rf_wdata;
    end

    assign bus.rf_rdata = bus.rf_ren ? rfMem[bus.rf_raddr] : '0;

    // Reference model: memory contents and each port's visible rdata.
    logic [DW-1:0] modelMem [16] = '{default: 8'h00};
    logic [DW-1:0] modelRdata [2] = '{default: 8'h00};

    logic [DW-1:0] expQ0 [$];
    logic [DW-1:0] expQ1 [$];
    int ackOrder [$];
    int ack1Cycles [$];

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;

    always @(posedge Clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive a command on one port and, when tracked, record its expected result.
    task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input bit track);
        logic [DW-1:0] e;
        if (we) begin
            if (track) modelMem[addr] = wdata;
            e = modelRdata[port];
        end else begin
            e = modelMem[addr];
            if (track) modelRdata[port] = e;
        end
        if (port == 0) begin
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
            if (track) expQ0.push_back(e);
        end else begin
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
            if (track) expQ1.push_back(e);
        end
    endtask

    task automatic releaseReq(input int port);
        if (port == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
    endtask

    task automatic waitAck(input int port, input int maxCycles, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < maxCycles) begin
            @(negedge Clk);
            n++;
            seen = (port == 0) ? bus.ack0 : bus.ack1;
        end
        if (!seen) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL ack timeout port%0d: got no ack, expected ack within %0d cycles",
                     port, maxCycles);
        end
    endtask

    task automatic runClient(input int port, input int n, input bit gaps,
                             input int lo, input int hi);
        int lat;
        for (int i = 0; i < n; i++) begin
            applyStimulus(port, 1'($urandom_range(1, 0)), 4'($urandom_range(hi, lo)),
                          8'($urandom), 1'b1);
            waitAck(port, 20, lat);
            checkOutput($sformatf("latency port%0d", port), 32'(lat >= 2 && lat <= 6), 1);
            if ((gaps && $urandom_range(1, 0) == 1) || i == n - 1) begin
                releaseReq(port);
                if (gaps) repeat ($urandom_range(2, 0)) @(negedge Clk);
            end
        end
    endtask

    // Monitor: compare each acked port's rdata against the queued expectation.
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst !== 1'b1) begin
                if (bus.ack0 || bus.ack1) begin
                    checkOutput("ack exclusive", 32'(bus.ack0 & bus.ack1), 0);
                end
                if (bus.ack0) begin
                    ackOrder.push_back(0);
                    if (expQ0.size() == 0) checkOutput("ack0 expected", 0, 1);
                    else checkOutput("rdata0", 32'(bus.rdata0), 32'(expQ0.pop_front()));
                end
                if (bus.ack1) begin
                    ackOrder.push_back(1);
                    ack1Cycles.push_back(cycleCount);
                    if (expQ1.size() == 0) checkOutput("ack1 expected", 0, 1);
                    else checkOutput("rdata1", 32'(bus.rdata1), 32'(expQ1.pop_front()));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        Rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        repeat (2) @(negedge Clk);

        // Reset values
        checkOutput("reset ack0", 32'(bus.ack0), 0);
        checkOutput("reset ack1", 32'(bus.ack1), 0);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset rf_ren", 32'(bus.rf_ren), 0);
        checkOutput("reset rf_wen", 32'(bus.rf_wen), 0);
        checkOutput("reset rf_raddr", 32'(bus.rf_raddr), 0);
        checkOutput("reset rf_waddr", 32'(bus.rf_waddr), 0);
        checkOutput("reset rf_wdata", 32'(bus.rf_wdata), 0);
        checkOutput("reset rdata0", 32'(bus.rdata0), 0);
        checkOutput("reset rdata1", 32'(bus.rdata1), 0);
        Rst = 1'b0;

        // Port 0 writes addr 3 = A5, cycle-by-cycle timing
        @(negedge Clk);
        applyStimulus(0, 1'b1, 4'd3, 8'hA5, 1'b1);
        @(negedge Clk);
        checkOutput("wr access rf_wen", 32'(bus.rf_wen), 1);
        checkOutput("wr access rf_ren", 32'(bus.rf_ren), 0);
        checkOutput("wr access rf_waddr", 32'(bus.rf_waddr), 3);
        checkOutput("wr access rf_wdata", 32'(bus.rf_wdata), 32'h A5);
        checkOutput("wr access busy", 32'(bus.busy), 1);
        checkOutput("wr access ack0", 32'(bus.ack0), 0);
        @(negedge Clk);
        checkOutput("wr resp ack0", 32'(bus.ack0), 1);
        checkOutput("wr resp rf_wen", 32'(bus.rf_wen), 0);
        checkOutput("wr resp busy", 32'(bus.busy), 1);
        releaseReq(0);
        @(negedge Clk);
        checkOutput("wr idle busy", 32'(bus.busy), 0);
        checkOutput("wr idle ack0", 32'(bus.ack0), 0);

        // Port 1 read aborted by reset during ACCESS
        applyStimulus(1, 1'b0, 4'd3, 8'h00, 1'b0);
        @(negedge Clk);
        checkOutput("abort access rf_ren", 32'(bus.rf_ren), 1);
        checkOutput("abort access rf_raddr", 32'(bus.rf_raddr), 3);
        Rst = 1'b1;
        releaseReq(1);
        @(negedge Clk);
        checkOutput("abort ack1", 32'(bus.ack1), 0);
        checkOutput("abort busy", 32'(bus.busy), 0);
        checkOutput("abort rf_ren", 32'(bus.rf_ren), 0);
        checkOutput("abort rdata1", 32'(bus.rdata1), 0);
        checkOutput("abort write kept", 32'(rfMem[3]), 32'(modelMem[3]));
        modelRdata[0] = '0;
        modelRdata[1] = '0;
        Rst = 1'b0;

        // Both request together: port 0 first (last restored to 1), then alternation
        @(negedge Clk);
        ackOrder.delete();
        fork
            runClient(0, 3, 1'b0, 0, 2);
            runClient(1, 3, 1'b0, 3, 3);
        join
        checkOutput("ack order count", 32'(ackOrder.size()), 6);
        for (int i = 0; i < ackOrder.size() && i < 6; i++) begin
            checkOutput($sformatf("ack order %0d", i), 32'(ackOrder[i]), 32'(i % 2));
        end

        // Read-after-write across ports
        @(negedge Clk);
        applyStimulus(0, 1'b1, 4'd9, 8'h3C, 1'b1);
        waitAck(0, 20, lat);
        releaseReq(0);
        applyStimulus(1, 1'b0, 4'd9, 8'h00, 1'b1);
        waitAck(1, 20, lat);
        checkOutput("raw rdata1", 32'(bus.rdata1), 32'h3C);
        checkOutput("raw rdata0 unchanged", 32'(bus.rdata0), 32'(modelRdata[0]));
        releaseReq(1);

        // Single requester back to back: acks every 3 cycles
        @(negedge Clk);
        ack1Cycles.delete();
        runClient(1, 4, 1'b0, 10, 12);
        checkOutput("solo ack count", 32'(ack1Cycles.size()), 4);
        for (int i = 1; i < ack1Cycles.size(); i++) begin
            checkOutput($sformatf("solo ack spacing %0d", i),
                        32'(ack1Cycles[i] - ack1Cycles[i-1]), 3);
        end

        // Address change during ACCESS is ignored
        @(negedge Clk);
        applyStimulus(0, 1'b1, 4'd3, 8'h5A, 1'b1);
        @(negedge Clk);
        checkOutput("addr hold access waddr", 32'(bus.rf_waddr), 3);
        bus.addr0 = 4'd7;
        @(negedge Clk);
        checkOutput("addr hold resp waddr", 32'(bus.rf_waddr), 3);
        checkOutput("addr hold resp ack0", 32'(bus.ack0), 1);
        releaseReq(0);
        @(negedge Clk);
        checkOutput("addr hold mem3", 32'(rfMem[3]), 32'h5A);
        checkOutput("addr hold mem7", 32'(rfMem[7]), 32'(modelMem[7]));

        // Randomized concurrent traffic on disjoint address halves
        fork
            runClient(0, 40, 1'b1, 0, 7);
            runClient(1, 40, 1'b1, 8, 15);
        join
        repeat (4) @(negedge Clk);
        checkOutput("queue0 drained", 32'(expQ0.size()), 0);
        checkOutput("queue1 drained", 32'(expQ1.size()), 0);
        for (int a = 0; a < 16; a++) begin
            checkOutput($sformatf("final mem %0d", a), 32'(rfMem[a]), 32'(modelMem[a]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and access sequencer for the shared 16x8 register file (`Register16_8`). It lets two independent FSM clients, such as a scan/min/sum engine and a loader, read and write the one register file without conflicts. Each client issues a request and waits for an acknowledge. The arbiter serialises the requests with round-robin fairness and drives the register file's read/write enables, addresses and write data. It sits between the clients and `Register16_8` in the lab top level; the register file itself is instantiated outside this block.

## Interface
- `DW`, 8, data width
- `AW`, 4, address width (16 entries)

- `Clk`  in  1  clock; all state changes on the rising edge
- `Rst`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  access request; held high with the command stable until the matching ack
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  target entry
- `wdata0`, `wdata1`  in  DW  write data
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata0`, `rdata1`  out  DW  read result; valid in the ack cycle and held until that port's next read ack
- `busy`  out  1  high in every state except IDLE
- `rf_raddr`, `rf_waddr`  out  AW  to the register file
- `rf_ren`, `rf_wen`  out  1  to the register file
- `rf_wdata`  out  DW  to the register file
- `rf_rdata`  in  DW  from the register file; combinational read data when `rf_ren` = 1

## Operation
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles, so there is at most one transaction per 3 cycles.
- IDLE:
  - If `req0` or `req1` is high, select one requester (rules below).
  - Latch that requester's `we`, `addr` and `wdata` into internal registers `cur_we`, `cur_addr`, `cur_wdata`, plus a 1-bit `cur_id`.
  - Go to ACCESS. Otherwise stay in IDLE.
- Selection:
  - Only one requester high: it wins.
  - Both high: the requester not in `last` wins.
  - `last` updates to `cur_id` on entry to RESP.
- ACCESS:
  - `rf_raddr` = `rf_waddr` = `cur_addr` and `rf_wdata` = `cur_wdata`, all registered.
  - Read: `rf_ren` = 1, `rf_wen` = 0; capture `rf_rdata` into the `rdata` register of port `cur_id` at the end of the cycle.
  - Write: `rf_wen` = 1, `rf_ren` = 0; no `rdata` changes.
  - Go to RESP.
- RESP:
  - `ack[cur_id]` = 1 for this cycle only; both rf enables = 0.
  - Go to IDLE.
- Client rule: deassert `req` (or present a new command) on the edge after the ack. A request still held in IDLE is treated as a new transaction.
- The arbiter never modifies data: no clamping and no arithmetic. Widths pass through unchanged.

## Timing
- Reset values:
  - state = IDLE, `last` = 1 (so `req0` wins the first tie)
  - `ack0` = `ack1` = 0, `busy` = 0
  - `rf_ren` = `rf_wen` = 0
  - `rf_raddr` = `rf_waddr` = 0, `rf_wdata` = 0
  - `rdata0` = `rdata1` = 0
- Latency: a request sampled high in IDLE at edge k produces:
  - rf enable high during cycle k+1
  - ack high during cycle k+2
  - state back in IDLE at edge k+3
- All outputs are registered; there is no combinational path from `req`/`addr` to `rf_*` or `ack`.
- Command inputs are sampled only in IDLE. Changes during ACCESS or RESP are ignored.
- Request dropped before grant: no effect. A request withdrawn after being latched still completes and is still acked.
- Simultaneous requests:
  - Both held continuously, with each re-requesting on the edge after its ack: grants alternate 0, 1, 0, 1, ...
  - Neither client is ever starved by more than one transaction.
- Read-after-write across ports:
  - A write by one port followed by a read of the same address by the other returns the new data.
  - The write-enable cycle always precedes the read-enable cycle.
- Reset mid-transaction (during ACCESS or RESP):
  - Transaction aborted; no ack is issued.
  - Write enable is dropped at the reset edge. A write whose ACCESS cycle has already completed is not rolled back.
  - `last` returns to 1.

## Structure
- Shared package `rf_arb_pkg`:
  - state encoding localparams `S_IDLE`, `S_ACCESS`, `S_RESP` (2-bit)
  - `DW`/`AW` defaults
  - requester ID constants `ID0`, `ID1`
- One sub-module, `rr_pick2`: combinational 2-way round-robin chooser.
  - Inputs `req0`, `req1`, `last`; outputs `valid`, `id`.
  - Instantiated once; the FSM and registers stay in `regfile_arbiter`.

## Test plan
- Reset, then `req0` writes addr 3 = 8'hA5 -> `rf_wen` = 1 with waddr 3 in cycle k+1; `ack0` in k+2; `busy` high for 2 cycles.
- `req1` reads addr 3 after that write, with the register file model instantiated -> `rf_ren` in k+1; `rdata1` = 8'hA5 with `ack1` in k+2; `rdata0` unchanged.
- Both request at once after reset -> port 0 granted first, port 1 second. Both held for 6 transactions -> ack order 0, 1, 0, 1, 0, 1.
- Only `req1` active, requesting repeatedly -> wins every time; acks every 3 cycles; no idle gap beyond the IDLE cycle.
- `Rst` asserted in the ACCESS cycle of a read -> no ack; `rdata` keeps its old value; next cycle IDLE, `busy` = 0, `last` = 1.
- Client changes `addr0` from 3 to 7 during ACCESS -> register file sees addr 3 only; transaction completes normally.
